// File: rtl/ethernet_pkg.sv
// Shared definitions for the MII receive path: controller states, framing
// nibbles, broadcast address and default length limits.
package ethernet_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_HUNT,
    ST_PREAMBLE,
    ST_DEST,
    ST_PAYLOAD,
    ST_DROP,
    ST_HOLD
  } rx_state_t;

  localparam logic [3:0]  PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  SFD_NIB      = 4'hD;
  localparam logic [47:0] BCAST_ADDR   = 48'hFFFF_FFFF_FFFF;
  localparam int          DEF_MAX_LEN  = 1518;
  localparam int          DEF_MIN_LEN  = 14;

endpackage

// File: rtl/ethernet_nibble_packer.sv
// Nibble-to-byte packer: tracks the nibble phase, assembles {high, low}
// bytes and issues the registered buffer write for each completed byte.
module ethernet_nibble_packer
  import ethernet_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic              wr_allow,
  input  logic [3:0]        nibble,
  input  logic [ADDR_W-1:0] addr,
  output logic              phase,
  output logic              byte_done,
  output logic [7:0]        byte_val,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  logic [3:0] lo_nib_p0;

  // A byte completes on the second (high) nibble of each pair.
  assign byte_done = accept & phase;
  assign byte_val  = {nibble, lo_nib_p0};

  // Stage p0: phase toggle and low-nibble latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase     <= 1'b0;
      lo_nib_p0 <= 4'h0;
    end else if (clear) begin
      phase     <= 1'b0;
    end else if (accept) begin
      if (!phase) lo_nib_p0 <= nibble;
      phase <= ~phase;
    end
  end

  // Stage p1: registered write strobe, address and data to the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'h00;
    end else begin
      wr_en <= byte_done & wr_allow;
      if (byte_done && wr_allow) begin
        wr_addr <= addr;
        wr_data <= byte_val;
      end
    end
  end

endmodule

// File: rtl/ethernet_rx_frame_ctrl.sv
// Frame-level receive controller: starts the nibble receiver, strips the
// preamble/SFD, filters on destination MAC, writes accepted frames into a
// single-frame buffer and hands them to the host with a valid/ack handshake.
module ethernet_rx_frame_ctrl
  import ethernet_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
  parameter int          MAX_LEN  = DEF_MAX_LEN,
  parameter int          MIN_LEN  = DEF_MIN_LEN,
  parameter int          ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              rx_start,
  input  logic              nibble_ready,
  input  logic [3:0]        nibble,
  input  logic              last_nibble,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_valid,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_error,
  input  logic              frame_ack,
  output logic [7:0]        overrun_cnt
);

  localparam logic [ADDR_W:0] MAX_L = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] MIN_L = (ADDR_W+1)'(MIN_LEN);

  rx_state_t       state, state_nxt;
  logic [ADDR_W:0] cnt_p0, cnt_nxt, fl_nxt;
  logic            uc_match, uc_nxt, bc_match, bc_nxt, oversize, ovs_nxt;
  logic            rx_start_nxt, fv_nxt, fe_nxt, runt;
  logic [7:0]      ovr_nxt, pk_byte;
  logic            pk_clear, pk_accept, pk_allow, pk_phase, pk_done, odd_nxt;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    mac_byte = MAC_ADDR[47:40];
      3'd1:    mac_byte = MAC_ADDR[39:32];
      3'd2:    mac_byte = MAC_ADDR[31:24];
      3'd3:    mac_byte = MAC_ADDR[23:16];
      3'd4:    mac_byte = MAC_ADDR[15:8];
      default: mac_byte = MAC_ADDR[7:0];
    endcase
  endfunction

  assign pk_accept = nibble_ready && (state == ST_DEST || state == ST_PAYLOAD);
  assign pk_allow  = !(state == ST_PAYLOAD && cnt_p0 >= MAX_L);
  // Phase after this cycle's nibble; a 1 here at end of carrier means a half byte.
  assign odd_nxt   = pk_phase ^ pk_accept;

  ethernet_nibble_packer #(.ADDR_W(ADDR_W)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .wr_allow  (pk_allow),
    .nibble    (nibble),
    .addr      (cnt_p0[ADDR_W-1:0]),
    .phase     (pk_phase),
    .byte_done (pk_done),
    .byte_val  (pk_byte),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Next state: apply the nibble first, then end of carrier on the result.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt_p0;
    uc_nxt       = uc_match;
    bc_nxt       = bc_match;
    ovs_nxt      = oversize;
    rx_start_nxt = 1'b0;
    fv_nxt       = frame_valid;
    fl_nxt       = frame_len;
    fe_nxt       = frame_error;
    ovr_nxt      = overrun_cnt;
    pk_clear     = 1'b0;
    runt         = 1'b0;

    case (state)
      ST_INIT: if (enable) begin
        rx_start_nxt = 1'b1;
        state_nxt    = ST_HUNT;
      end
      ST_HUNT: if (enable && nibble_ready) begin
        state_nxt = (nibble == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
      end
      ST_PREAMBLE: if (nibble_ready) begin
        if (nibble == SFD_NIB) begin
          state_nxt = ST_DEST;
          cnt_nxt   = '0;
          pk_clear  = 1'b1;
          uc_nxt    = 1'b1;
          bc_nxt    = 1'b1;
        end else if (nibble != PREAMBLE_NIB) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DEST: if (pk_done) begin
        cnt_nxt = cnt_p0 + 1'b1;
        uc_nxt  = uc_match && (pk_byte == mac_byte(cnt_p0[2:0]));
        bc_nxt  = bc_match && (pk_byte == BCAST_ADDR[7:0]);
        if (cnt_p0 == 5) state_nxt = (uc_nxt || bc_nxt) ? ST_PAYLOAD : ST_DROP;
      end
      ST_PAYLOAD: if (pk_done) begin
        if (cnt_p0 >= MAX_L) begin
          ovs_nxt   = 1'b1;
          state_nxt = ST_DROP;
        end else begin
          cnt_nxt = cnt_p0 + 1'b1;
        end
      end
      ST_HOLD: begin
        if (last_nibble && overrun_cnt != 8'hFF) ovr_nxt = overrun_cnt + 8'd1;
        if (frame_ack) begin
          state_nxt = ST_HUNT;
          fv_nxt    = 1'b0;
          fl_nxt    = '0;
          fe_nxt    = 1'b0;
          ovs_nxt   = 1'b0;
        end
      end
      default: ;
    endcase

    if (last_nibble && state != ST_HOLD) begin
      case (state_nxt)
        ST_PREAMBLE: state_nxt = ST_HUNT;
        ST_DEST, ST_PAYLOAD: begin
          runt      = (state_nxt == ST_DEST);
          state_nxt = ST_HOLD;
          fv_nxt    = 1'b1;
          fl_nxt    = cnt_nxt;
          fe_nxt    = odd_nxt | (cnt_nxt < MIN_L) | ovs_nxt | runt;
        end
        ST_DROP: begin
          if (ovs_nxt) begin
            state_nxt = ST_HOLD;
            fv_nxt    = 1'b1;
            fl_nxt    = MAX_L;
            fe_nxt    = 1'b1;
          end else begin
            state_nxt = ST_HUNT;
          end
        end
        default: ;
      endcase
    end
  end

  // State, counters, filter flags and registered host-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_INIT;
      cnt_p0      <= '0;
      uc_match    <= 1'b0;
      bc_match    <= 1'b0;
      oversize    <= 1'b0;
      rx_start    <= 1'b0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_error <= 1'b0;
      overrun_cnt <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt_p0      <= cnt_nxt;
      uc_match    <= uc_nxt;
      bc_match    <= bc_nxt;
      oversize    <= ovs_nxt;
      rx_start    <= rx_start_nxt;
      frame_valid <= fv_nxt;
      frame_len   <= fl_nxt;
      frame_error <= fe_nxt;
      overrun_cnt <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_ethernet_rx_frame_ctrl.sv
// Bench for ethernet_rx_frame_ctrl: directed and randomized frames checked
// against a frame-level reference model that parses whole nibble streams.
module tb_ethernet_rx_frame_ctrl;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam int MAXL = 1518;
  localparam int MINL = 14;
  localparam int AW   = 11;

  logic          clk = 1'b0;
  logic          reset, enable, nibble_ready, last_nibble, frame_ack;
  logic [3:0]    nibble;
  logic          rx_start, wr_en, frame_valid, frame_error;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data, overrun_cnt;
  logic [AW:0]   frame_len;

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;

  logic [3:0]    nq[$];
  logic [AW+7:0] got_w[$];
  logic [AW+7:0] exp_w[$];

  // Reference model state: frame held for the host, its report, overrun count.
  bit m_hold;
  int m_len;
  bit m_err;
  int m_ovr;

  ethernet_rx_frame_ctrl #(.MAC_ADDR(MAC), .MAX_LEN(MAXL), .MIN_LEN(MINL), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .rx_start     (rx_start),
    .nibble_ready (nibble_ready),
    .nibble       (nibble),
    .last_nibble  (last_nibble),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .frame_valid  (frame_valid),
    .frame_len    (frame_len),
    .frame_error  (frame_error),
    .frame_ack    (frame_ack),
    .overrun_cnt  (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Capture buffer writes and start pulses away from the active edge.
  always @(negedge clk) begin
    if (wr_en) got_w.push_back({wr_addr, wr_data});
    if (rx_start) rx_pulses++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  // Preamble (15 x 0x5), SFD, then nbytes bytes (DA first), optional half byte.
  task automatic build_frame(input logic [47:0] da, input int nbytes, input bit odd);
    logic [7:0] b;
    nq.delete();
    repeat (15) nq.push_back(4'h5);
    nq.push_back(4'hD);
    for (int k = 0; k < nbytes; k++) begin
      if (k < 6) b = da[8*(5-k) +: 8];
      else       b = 8'($urandom);
      nq.push_back(b[3:0]);
      nq.push_back(b[7:4]);
    end
    if (odd) nq.push_back(4'($urandom));
  endtask

  // Frame-level model: parse the whole stream and predict writes and report.
  task automatic model_frame();
    int i, nn, nb, wn;
    bit odd;
    logic [7:0]  b[$];
    logic [47:0] da;
    exp_w.delete();
    if (m_hold) begin
      if (m_ovr < 255) m_ovr++;
      return;
    end
    i = 0;
    while (i < nq.size() && nq[i] == 4'h5) i++;
    if (i == 0 || i >= nq.size() || nq[i] != 4'hD) return;
    nn  = nq.size() - i - 1;
    nb  = nn / 2;
    odd = (nn % 2) != 0;
    for (int k = 0; k < nb; k++) b.push_back({nq[i+2+2*k], nq[i+1+2*k]});
    if (nb >= 6) begin
      da = {b[0], b[1], b[2], b[3], b[4], b[5]};
      if (da != MAC && da != BCAST) begin
        for (int k = 0; k < 6; k++) exp_w.push_back({AW'(k), b[k]});
        return;
      end
    end
    wn = (nb > MAXL) ? MAXL : nb;
    for (int k = 0; k < wn; k++) exp_w.push_back({AW'(k), b[k]});
    m_hold = 1'b1;
    m_len  = wn;
    m_err  = odd || (wn < MINL) || (nb > MAXL) || (nb < 6);
  endtask

  // Drive the stream one nibble per cycle, last_nibble with the final nibble.
  task automatic run_frame();
    model_frame();
    got_w.delete();
    for (int i = 0; i < nq.size(); i++) begin
      nibble_ready = 1'b1;
      nibble       = nq[i];
      last_nibble  = (i == nq.size() - 1);
      @(posedge clk); #1;
    end
    nibble_ready = 1'b0;
    last_nibble  = 1'b0;
    nibble       = 4'h0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    m_hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; nibble_ready = 1'b0; last_nibble = 1'b0;
    nibble = 4'h0; frame_ack = 1'b0;
    m_hold = 1'b0; m_ovr = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_start, wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_error, overrun_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rx_start=%b wr_en=%b fv=%b len=%0d err=%b ovr=%0d, all required 0",
               rx_start, wr_en, frame_valid, frame_len, frame_error, overrun_cnt);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_start !== 1'b0) begin
      errors++;
      $display("FAIL init_wait: rx_start=%b while enable low, required 0", rx_start);
    end
    enable = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rx_start !== 1'b1) begin
      errors++;
      $display("FAIL rx_start_pulse: rx_start=%b, required 1", rx_start);
    end
    @(posedge clk); #1;
    checks++;
    if (rx_start !== 1'b0) begin
      errors++;
      $display("FAIL rx_start_width: rx_start=%b, required 0", rx_start);
    end
  endtask

  task automatic test_unicast();
    build_frame(MAC, 60, 1'b0);
    run_frame();
    checks++;
    if (got_w.size() !== 60) begin
      errors++;
      $display("FAIL unicast_wr_count: %0d writes, required 60", got_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
      checks++;
      if (got_w[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL unicast_wr[%0d]: addr %0d data %h, required addr %0d data %h", k,
                 got_w[k][AW+7:8], got_w[k][7:0], exp_w[k][AW+7:8], exp_w[k][7:0]);
      end
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd60 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL unicast_report: fv=%b len=%0d err=%b, required fv=1 len=60 err=0",
               frame_valid, frame_len, frame_error);
    end
    do_ack();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL unicast_ack: fv=%b after ack, required 0", frame_valid);
    end
  endtask

  task automatic test_filter();
    build_frame(BCAST, 64, 1'b0);
    run_frame();
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd64 || frame_error !== 1'b0 || got_w.size() !== 64) begin
      errors++;
      $display("FAIL bcast_report: fv=%b len=%0d err=%b writes=%0d, required 1/64/0/64",
               frame_valid, frame_len, frame_error, got_w.size());
    end
    do_ack();
    build_frame(48'h02_00_00_00_00_02, 30, 1'b0);
    run_frame();
    checks++;
    if (frame_valid !== 1'b0 || got_w.size() !== exp_w.size()) begin
      errors++;
      $display("FAIL da_reject: fv=%b writes=%0d, required fv=0 writes=%0d",
               frame_valid, got_w.size(), exp_w.size());
    end
    build_frame(MAC, 20, 1'b0);
    run_frame();
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd20 || frame_error !== 1'b0) begin
      errors++;
      $display("FAIL after_reject: fv=%b len=%0d err=%b, required 1/20/0",
               frame_valid, frame_len, frame_error);
    end
    do_ack();
  endtask

  task automatic test_length_errors();
    int lens[6] = '{1600, 1518, 10, 20, 14, 13};
    bit odds[6] = '{0, 0, 0, 1, 0, 0};
    for (int t = 0; t < 6; t++) begin
      build_frame(MAC, lens[t], odds[t]);
      run_frame();
      checks++;
      if (frame_valid !== 1'b1 || frame_len !== 12'(m_len) || frame_error !== m_err) begin
        errors++;
        $display("FAIL len_case_%0d: fv=%b len=%0d err=%b, required 1/%0d/%b",
                 lens[t], frame_valid, frame_len, frame_error, m_len, m_err);
      end
      checks++;
      if (got_w.size() !== exp_w.size() ||
          (got_w.size() > 0 && got_w[got_w.size()-1] !== exp_w[exp_w.size()-1])) begin
        errors++;
        $display("FAIL len_writes_%0d: %0d writes, required %0d (last addr %0d)",
                 lens[t], got_w.size(), exp_w.size(), exp_w.size() - 1);
      end
      do_ack();
    end
  endtask

  task automatic test_bad_preamble();
    build_frame(MAC, 20, 1'b0);
    nq[5] = 4'h7;
    run_frame();
    checks++;
    if (got_w.size() !== 0 || frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_preamble: writes=%0d fv=%b, required 0/0", got_w.size(), frame_valid);
    end
    build_frame(MAC, 16, 1'b0);
    run_frame();
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd16 || frame_error !== 1'b0 || got_w.size() !== 16) begin
      errors++;
      $display("FAIL after_bad_preamble: fv=%b len=%0d err=%b writes=%0d, required 1/16/0/16",
               frame_valid, frame_len, frame_error, got_w.size());
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [47:0] da;
    int sel;
    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      da = BCAST;
      else if (sel == 1) da = 48'h0A00_0000_0000 | 48'($urandom);
      else               da = MAC;
      build_frame(da, $urandom_range(0, 90), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 5) == 0) nq[$urandom_range(0, 14)] = 4'($urandom_range(6, 15));
      run_frame();
      checks++;
      if (got_w.size() !== exp_w.size()) begin
        errors++;
        $display("FAIL rand_%0d_wr_count: %0d writes, required %0d", it, got_w.size(), exp_w.size());
      end
      for (int k = 0; k < exp_w.size() && k < got_w.size(); k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL rand_%0d_wr[%0d]: %h, required %h", it, k, got_w[k], exp_w[k]);
        end
      end
      checks++;
      if (frame_valid !== m_hold ||
          (m_hold && (frame_len !== 12'(m_len) || frame_error !== m_err))) begin
        errors++;
        $display("FAIL rand_%0d_report: fv=%b len=%0d err=%b, required %b/%0d/%b",
                 it, frame_valid, frame_len, frame_error, m_hold, m_len, m_err);
      end
      if (m_hold) begin
        do_ack();
        checks++;
        if (frame_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_%0d_ack: fv=%b, required 0", it, frame_valid);
        end
      end
    end
  endtask

  task automatic test_overrun();
    int total_w;
    build_frame(MAC, 20, 1'b0);
    run_frame();
    total_w = 0;
    for (int f = 0; f < 3; f++) begin
      build_frame(MAC, 2, 1'b0);
      run_frame();
      total_w += got_w.size();
    end
    checks++;
    if (overrun_cnt !== 8'(m_ovr) || m_ovr != 3 || total_w != 0) begin
      errors++;
      $display("FAIL overrun_3: cnt=%0d writes=%0d, required cnt=3 writes=0", overrun_cnt, total_w);
    end
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd20) begin
      errors++;
      $display("FAIL hold_stable: fv=%b len=%0d, required 1/20", frame_valid, frame_len);
    end
    for (int f = 0; f < 297; f++) begin
      build_frame(BCAST, 2, 1'b0);
      run_frame();
    end
    checks++;
    if (overrun_cnt !== 8'(m_ovr) || overrun_cnt !== 8'd255) begin
      errors++;
      $display("FAIL overrun_sat: cnt=%0d, required 255", overrun_cnt);
    end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    int pulses;
    build_frame(MAC, 40, 1'b0);
    for (int i = 0; i < 50; i++) begin
      nibble_ready = 1'b1;
      nibble       = nq[i];
      @(posedge clk); #1;
    end
    nibble_ready = 1'b0;
    nibble       = 4'h0;
    #2 reset = 1'b1;
    enable = 1'b0;
    #1;
    checks++;
    if ({rx_start, wr_en, wr_addr, wr_data, frame_valid, frame_len, frame_error, overrun_cnt} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: wr_en=%b addr=%0d fv=%b ovr=%0d, all required 0",
               wr_en, wr_addr, frame_valid, overrun_cnt);
    end
    m_hold = 1'b0;
    m_ovr  = 0;
    @(posedge clk); #1;
    reset  = 1'b0;
    pulses = rx_pulses;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rx_pulses != pulses + 1) begin
      errors++;
      $display("FAIL restart_pulse: %0d rx_start pulses after re-enable, required 1", rx_pulses - pulses);
    end
    build_frame(MAC, 30, 1'b0);
    run_frame();
    checks++;
    if (frame_valid !== 1'b1 || frame_len !== 12'd30 || frame_error !== 1'b0 || got_w.size() !== 30) begin
      errors++;
      $display("FAIL after_reset_frame: fv=%b len=%0d err=%b writes=%0d, required 1/30/0/30",
               frame_valid, frame_len, frame_error, got_w.size());
    end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_filter();
    test_length_errors();
    test_bad_preamble();
    test_random();
    test_overrun();
    test_reset_midframe();
    checks++;
    if (rx_pulses != 2) begin
      errors++;
      $display("FAIL rx_start_total: %0d pulses, required 2", rx_pulses);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
